// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-bus arbiter: FSM state codes and watchdog defaults.
package pipe_mem_arbiter_pkg;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
    localparam int unsigned WAIT_CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-cycle counter for one bus transaction; o_tc_c flags the last allowed wait cycle.
module bus_wait_timer
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int unsigned TC = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    logic [WAIT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + WAIT_CNT_W'(1);
        end
    end

    // Asserted while the current cycle is the TC-th unacknowledged wait cycle.
    assign o_tc_c = (r_cnt == WAIT_CNT_W'(TC - 1));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Serialises MEM and IF accesses onto one single-port bus (MEM first), stalls the pipeline
// while an access is outstanding and aborts hung transactions via a wait-cycle watchdog.
module pipe_mem_arbiter
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall,
    output logic              bus_err
);

    arb_state_e        r_state, w_state_nxt;
    logic              r_bus_req, w_bus_req_nxt;
    logic              r_bus_we, w_bus_we_nxt;
    logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_nxt;
    logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
    logic              r_bus_err, w_bus_err_nxt;

    logic w_busy;
    logic w_ack;
    logic w_abort;
    logic w_xfer_end;
    logic w_issue;
    logic w_tc;

    assign w_busy     = (r_state == ST_DATA) || (r_state == ST_FETCH);
    assign w_ack      = w_busy && r_bus_req && bus_ack;
    assign w_abort    = w_busy && !w_ack && w_tc;
    assign w_xfer_end = w_ack || w_abort;

    bus_wait_timer #(
        .TC (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_issue),
        .i_en   (w_busy && !w_ack),
        .o_tc_c (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    // Next-state and next-register logic; a fetch can chain directly off a finished data access.
    always_comb begin
        w_state_nxt     = r_state;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;
        w_bus_err_nxt   = r_bus_err;
        w_issue         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = mem_we;
                    w_bus_addr_nxt  = mem_addr;
                    w_bus_wdata_nxt = mem_wdata;
                    w_issue         = 1'b1;
                    w_state_nxt     = ST_DATA;
                end else if (if_req) begin
                    w_bus_req_nxt  = 1'b1;
                    w_bus_we_nxt   = 1'b0;
                    w_bus_addr_nxt = if_addr;
                    w_issue        = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end
            end
            ST_DATA: begin
                if (w_xfer_end) begin
                    // Stores have no destination, so their completion leaves mem_rdata alone.
                    if (!r_bus_we) begin
                        w_mem_rdata_nxt = w_ack ? bus_rdata : '0;
                    end
                    w_bus_err_nxt = r_bus_err || w_abort;
                    if (if_req) begin
                        w_bus_req_nxt  = 1'b1;
                        w_bus_we_nxt   = 1'b0;
                        w_bus_addr_nxt = if_addr;
                        w_issue        = 1'b1;
                        w_state_nxt    = ST_FETCH;
                    end else begin
                        w_bus_req_nxt = 1'b0;
                        w_state_nxt   = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (w_xfer_end) begin
                    w_if_rdata_nxt = w_ack ? bus_rdata : '0;
                    w_bus_err_nxt  = r_bus_err || w_abort;
                    w_bus_req_nxt  = 1'b0;
                    w_state_nxt    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stall = w_busy || ((r_state == ST_IDLE) && (if_req || mem_req));

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign bus_err   = r_bus_err;

endmodule
